// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame transmitter.
//   - DEFAULT_SYNC_BYTE : default header byte sent first in every frame
//   - FRAME_LEN         : bytes per frame (4, or 5 with the checksum byte)
//   - state_e           : transmitter FSM states
// Build option: FRAME_TX_CHECKSUM_EN adds the CSUM state and a fifth frame byte.
package frame_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

`ifdef FRAME_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StB0,
        StB1,
        StB2,
        StCsum
    } state_e;
`else
    localparam int unsigned FRAME_LEN = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StB0,
        StB1,
        StB2
    } state_e;
`endif

endpackage

// File: rtl/frame_csum.sv
// frame_csum: combinational frame checksum, sum of the three payload bytes modulo 256.
// Ports:
//   data  in  24  payload word (byte0=[7:0], byte1=[15:8], byte2=[23:16])
//   csum  out  8  byte0 + byte1 + byte2, truncated to 8 bits
module frame_csum (
    input  logic [23:0] data,
    output logic [7:0]  csum
);

    // 8-bit sum width truncates the carry, giving the modulo-256 result.
    assign csum = data[7:0] + data[15:8] + data[23:16];

endmodule

// File: rtl/frame_tx.sv
// frame_tx: serialises a 24-bit payload into a byte frame for a UART transmitter.
// Frame: SYNC_BYTE, byte0, byte1, byte2 (and, with FRAME_TX_CHECKSUM_EN defined, a
// checksum byte equal to byte0+byte1+byte2 modulo 256).
// Ports:
//   clk          in         clock, rising edge
//   rst          in         asynchronous active-high reset
//   in_data      in  24     payload word
//   in_valid     in         payload offered
//   in_ready     out        payload can be accepted (IDLE only)
//   out_data     out  8     byte to the UART transmitter
//   out_valid    out        out_data valid
//   out_ready    in         UART transmitter accepts the byte
//   busy         out        frame in progress
//   frames_sent  out CNT_W  completed-frame counter, wraps modulo 2^CNT_W
module frame_tx
    import frame_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    state_e             state_q, state_d;
    logic [23:0]        hold_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               frame_done;

`ifdef FRAME_TX_CHECKSUM_EN
    logic [7:0] csum;

    frame_csum u_csum (
        .data (hold_q),
        .csum (csum)
    );
`endif

    // Outputs decode purely from state so that a stalled byte stays stable
    // until the transmitter takes it.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b1;
        out_data   = 8'h00;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                if (in_valid) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                out_data = SYNC_BYTE;
                if (out_ready) begin
                    state_d = StB0;
                end
            end
            StB0: begin
                out_data = hold_q[7:0];
                if (out_ready) begin
                    state_d = StB1;
                end
            end
            StB1: begin
                out_data = hold_q[15:8];
                if (out_ready) begin
                    state_d = StB2;
                end
            end
            StB2: begin
                out_data = hold_q[23:16];
                if (out_ready) begin
`ifdef FRAME_TX_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d    = StIdle;
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef FRAME_TX_CHECKSUM_EN
            StCsum: begin
                out_data = csum;
                if (out_ready) begin
                    state_d    = StIdle;
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d   = StIdle;
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Only the holding register is transmitted, so in_data may change freely
    // once the payload has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 24'h000000;
        end else if (in_valid && in_ready) begin
            hold_q <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (frame_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign busy        = (state_q != StIdle);
    assign frames_sent = cnt_q;

endmodule

// File: tb/tb_frame_tx.sv
module tb_frame_tx;
    import frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [7:0]  out_data;
    logic [15:0] frames_sent;

    logic        in_ready_w2, out_valid_w2, busy_w2;
    logic [7:0]  out_data_w2;
    logic [1:0]  frames_sent_w2;

    frame_tx #(.SYNC_BYTE(8'hAA), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    // Narrow-counter instance, same stimulus, exercises wraparound.
    frame_tx #(.SYNC_BYTE(8'hAA), .CNT_W(2)) dut_w2 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready_w2),
        .out_data    (out_data_w2),
        .out_valid   (out_valid_w2),
        .out_ready   (out_ready),
        .busy        (busy_w2),
        .frames_sent (frames_sent_w2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of bytes still owed for the current frame.
    logic [7:0] exp_q[$];
    int         model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [23:0] p);
        int s;
        s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
        exp_q.push_back(8'hAA);
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[23:16]);
        if (FRAME_LEN == 5) exp_q.push_back(8'(s % 256));
    endtask

    // Check outputs against the model, advance one clock, then update the model.
    task automatic cycle();
        logic        ov, ordy, iv, ir;
        logic [23:0] id;
        ov = out_valid; ordy = out_ready; iv = in_valid; ir = in_ready; id = in_data;
        chk("out_valid", ov, exp_q.size() != 0);
        chk("in_ready", ir, exp_q.size() == 0);
        chk("busy", busy, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        chk("frames_sent", frames_sent, 32'(model_cnt % 65536));
        chk("frames_sent_w2", frames_sent_w2, 32'(model_cnt % 4));
        @(posedge clk);
        #1;
        if (ov && ordy && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) model_cnt++;
        end else if (iv && ir && exp_q.size() == 0) begin
            push_frame(id);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = 0;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [23:0] payload;
        logic [7:0]  csum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] e;
        int idles;

        vecs[0] = '{24'h332211, 8'h66};
        vecs[1] = '{24'hF0F0F0, 8'hD0};
        vecs[2] = '{24'hFFFFFF, 8'hFD};
        vecs[3] = '{24'h000000, 8'h00};
        vecs[4] = '{24'h0102FF, 8'h02};

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_sent, 0);
        rst = 1'b0;

        // Table-driven frames with out_ready tied high.
        for (int i = 0; i < 5; i++) begin
            in_data = vecs[i].payload; in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            for (int k = 0; k < int'(FRAME_LEN); k++) begin
                if (k == 0) e = 8'hAA;
                else if (k < 4) e = vecs[i].payload[8*(k-1) +: 8];
                else e = vecs[i].csum;
                chk("tbl_valid", out_valid, 1);
                chk("tbl_byte", out_data, e);
                cycle();
            end
            chk("tbl_busy_end", busy, 0);
            chk("tbl_count", frames_sent, 32'(i + 1));
        end

        // Stall for 5 cycles while byte1 is presented.
        in_data = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_data", out_data, 8'h22);
            chk("stall_valid", out_valid, 1);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("resume_data", out_data, 8'h33);
        for (int k = 0; k < 8 && busy; k++) cycle();
        chk("stall_frame_end", busy, 0);

        // in_data rewritten mid-frame must not affect transmitted bytes.
        in_data = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_data = 24'hFFFFFF;
        for (int k = 0; k < int'(FRAME_LEN); k++) begin
            if (k == 0) e = 8'hAA;
            else if (k < 4) e = 8'(8'h11 * k);
            else e = 8'h66;
            chk("midchg_in_ready", in_ready, 0);
            chk("midchg_byte", out_data, e);
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Asynchronous reset while in B0.
        in_data = 24'h332211; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("pre_rst_b0", out_data, 8'h11);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_frames", frames_sent, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = 0;
        rst = 1'b0;
        in_data = 24'h332211; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_sync", out_data, 8'hAA);
        for (int k = 0; k < 8 && busy; k++) cycle();
        chk("post_rst_count", frames_sent, 1);

        // Five back-to-back frames, in_valid held high; narrow counter wraps to 1.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; idles = 0;
        for (int c = 0; c < 5 * (int'(FRAME_LEN) + 1); c++) begin
            in_data = $urandom;
            if (in_ready) idles++;
            cycle();
        end
        in_valid = 1'b0;
        chk("b2b_idle_cycles", idles, 5);
        chk("b2b_frames_w2", frames_sent_w2, 1);
        chk("b2b_frames", frames_sent, 5);
        cycle();

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
